etpu_wb_host: RTL and testbench

Wishbone classic-cycle initiator that drives the edu TPU slave at `TARGET_ADDR` through one complete job:
- write the weight words,
- stream the input words,
- wait for the systolic array to finish,
- read the result words back into a local buffer.

It sits on the master side of the same Wishbone link the TPU answers on. It is used for on-chip self-test and for a local controller that has no direct bus access. A local load/readback port holds the job data, and a single `start_i` pulse runs the whole sequence.

---
 rtl/etpu_wb_host.sv | 148 ++++++++++++++
 tb/tb_etpu_wb_host.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etpu_wb_host.sv
// etpu_wb_host: Wishbone classic-cycle initiator that runs one complete edu-TPU job
// (weight writes, input writes, run wait, result readback) from a local job register file.
module etpu_wb_host #(
  parameter logic [31:0] TARGET_ADDR = 32'h3000_0000,
  parameter int unsigned N_WEIGHTS   = 4,
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned N_RESULTS   = 5,
  parameter int unsigned RUN_WAIT    = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  input  logic        ld_we_i,
  input  logic [2:0]  ld_addr_i,
  input  logic [31:0] ld_data_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [2:0]  res_addr_i,
  output logic [31:0] res_data_o
);

  typedef enum logic [2:0] {IDLE, WR_W, WR_IN, WAIT, RD, GAP, DONE} state_t;

  localparam logic [2:0]  LAST_W   = 3'(N_WEIGHTS - 1);
  localparam logic [2:0]  LAST_IN  = 3'(N_INPUTS - 1);
  localparam logic [2:0]  LAST_RD  = 3'(N_RESULTS - 1);
  localparam logic [15:0] WAIT_END = 16'(RUN_WAIT - 1);
  localparam logic [15:0] TMO_END  = 16'(TIMEOUT - 1);

  state_t      state, state_nxt, phase;
  logic [2:0]  cnt, last_idx;
  logic        last_q, in_xfer, tmo_hit, err_pend;
  logic [15:0] wait_cnt, tmo_cnt;
  logic [31:0] job_regs [8];
  logic [31:0] results  [8];

  assign in_xfer    = (state == WR_W) || (state == WR_IN) || (state == RD);
  assign tmo_hit    = in_xfer && !wbm_ack_i && (tmo_cnt == TMO_END);
  assign res_data_o = results[res_addr_i];

  always_comb begin
    state_nxt = state;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = 32'h0;
    wbm_dat_o = 32'h0;
    last_idx  = LAST_RD;
    case (state)
      IDLE: if (start_i) state_nxt = WR_W;
      WR_W, WR_IN, RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = TARGET_ADDR;
        wbm_we_o  = (state != RD);
        if (state == WR_W) begin
          wbm_dat_o = job_regs[{1'b0, cnt[1:0]}];
          last_idx  = LAST_W;
        end else if (state == WR_IN) begin
          wbm_dat_o = job_regs[{1'b1, cnt[1:0]}];
          last_idx  = LAST_IN;
        end
        if (wbm_ack_i)    state_nxt = GAP;
        else if (tmo_hit) state_nxt = DONE;
      end
      // The slave's registered ack lingers one cycle, so every transaction is followed by an idle GAP.
      GAP: begin
        if (!last_q)              state_nxt = phase;
        else if (phase == WR_W)   state_nxt = WR_IN;
        else if (phase == WR_IN)  state_nxt = WAIT;
        else                      state_nxt = DONE;
      end
      WAIT: if (wait_cnt == WAIT_END) state_nxt = RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      state    <= IDLE;
      phase    <= IDLE;
      cnt      <= 3'd0;
      last_q   <= 1'b0;
      wait_cnt <= 16'd0;
      tmo_cnt  <= 16'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      err_pend <= 1'b0;
      for (int i = 0; i < 8; i++) results[i] <= 32'h0;
    end else begin
      state  <= state_nxt;
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          busy_o   <= 1'b1;
          err_o    <= 1'b0;
          err_pend <= 1'b0;
          cnt      <= 3'd0;
          tmo_cnt  <= 16'd0;
        end
        WR_W, WR_IN, RD: begin
          if (wbm_ack_i) begin
            if (state == RD) results[cnt] <= wbm_dat_i;
            last_q <= (cnt == last_idx);
            cnt    <= cnt + 3'd1;
            phase  <= state;
          end else if (tmo_hit) begin
            err_pend <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        GAP: begin
          tmo_cnt  <= 16'd0;
          wait_cnt <= 16'd0;
          if (last_q) cnt <= 3'd0;
        end
        WAIT: wait_cnt <= wait_cnt + 16'd1;
        // The error flag is published together with the done pulse.
        DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          err_o  <= err_pend;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (ld_we_i && !busy_o) job_regs[ld_addr_i] <= ld_data_i;
  end

endmodule

// File: tb/tb_etpu_wb_host.sv
// tb_etpu_wb_host: directed jobs against a latency-programmable Wishbone slave, with a
// transaction-level scoreboard and a per-cycle bus checker.
module tb_etpu_wb_host;
  localparam logic [31:0] TARGET = 32'h3000_0000;
  localparam int NW = 4, NI = 4, NR = 5, RW = 32, TMO = 255;
  localparam int NWORDS = NW + NI + NR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ld_we = 1'b0;
  logic [2:0]  ld_addr = 3'd0;
  logic [31:0] ld_data = 32'h0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [2:0]  res_addr = 3'd0;
  logic [31:0] res_data;

  etpu_wb_host dut (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err),
    .res_addr_i(res_addr), .res_data_o(res_data)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  // Registered-ack slave: ack rises lat cycles after stb and repeats while stb stays high.
  int          lat = 1;
  bit          never_ack = 1'b0, spur = 1'b0;
  int          stb_age = 0;
  logic        slv_ack = 1'b0;
  logic [2:0]  rd_idx = 3'd0;
  logic [31:0] rd_words [8];
  assign ack   = slv_ack | spur;
  assign dat_i = rd_words[rd_idx];

  always @(posedge clk) begin
    if (rst || !stb) begin
      stb_age <= 0;
      slv_ack <= 1'b0;
    end else begin
      stb_age <= stb_age + 1;
      slv_ack <= !never_ack && (stb_age + 1 >= lat);
      if (slv_ack && !we) rd_idx <= rd_idx + 3'd1;
    end
    if (!busy) rd_idx <= 3'd0;
  end

  typedef struct packed { logic we; logic [31:0] dat; } txn_t;
  txn_t        exp_q [$];
  logic [31:0] model_job [8];
  logic [31:0] model_res [8];
  int          reads_seen = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int job_len(input int l);
    return (l + 2) * NWORDS + RW + 2;
  endfunction

  int          stb_len = 0, idle_run = 0;
  bit          prev_stb = 1'b0, prev_acc = 1'b0;
  logic        prev_we, acc;
  logic [31:0] prev_dat;
  txn_t        t;

  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0; prev_acc = 1'b0; stb_len = 0; idle_run = 0;
    end else begin
      acc = stb && ack;
      check_output("bus_shape", 64'({cyc, sel, adr, we & ~stb}),
                   stb ? 64'({1'b1, 4'hF, TARGET, 1'b0}) : 64'd0);
      if (prev_acc) check_output("gap_after_ack", 64'(stb), 64'd0);
      if (stb && prev_stb && !prev_acc)
        check_output("hold_stable", 64'({we, dat_o}), 64'({prev_we, prev_dat}));
      if (!stb && prev_stb && !prev_acc) check_output("timeout_len", 64'(stb_len), 64'(TMO));
      if (stb && !prev_stb) begin
        check_output("txn_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0 && !exp_q[0].we && reads_seen == 0)
          check_output("idle_before_read", 64'(idle_run), 64'(RW + 1));
        stb_len = 1;
      end else if (stb) begin
        stb_len++;
      end
      if (acc) begin
        check_output("stb_len", 64'(stb_len), 64'(lat + 1));
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          check_output("txn_we", 64'(we), 64'(t.we));
          if (t.we) check_output("txn_data", 64'(dat_o), 64'(t.dat));
          else begin
            model_res[reads_seen] = rd_words[reads_seen];
            reads_seen++;
          end
        end
      end
      idle_run = stb ? 0 : idle_run + 1;
      prev_stb = stb; prev_acc = acc; prev_we = we; prev_dat = dat_o;
    end
  end

  task automatic apply_stimulus(input logic [2:0] a, input logic [31:0] v);
    @(posedge clk); #1 ld_we = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1 ld_we = 1'b0;
    model_job[a] = v;
  endtask

  task automatic build_expect();
    txn_t x;
    exp_q.delete();
    reads_seen = 0;
    for (int i = 0; i < NW; i++) begin x.we = 1'b1; x.dat = model_job[i];     exp_q.push_back(x); end
    for (int i = 0; i < NI; i++) begin x.we = 1'b1; x.dat = model_job[4 + i]; exp_q.push_back(x); end
    for (int i = 0; i < NR; i++) begin x.we = 1'b0; x.dat = 32'h0;            exp_q.push_back(x); end
  endtask

  task automatic start_job(output int start_edge);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_edge = cycle;
    @(negedge clk);
    check_output("start_busy_stb_err", 64'({busy, stb, err}), 64'b110);
  endtask

  task automatic wait_done(input int budget, output int done_edge, output logic e, output logic b);
    int n = 0;
    done_edge = -1; e = 1'b0; b = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      if (done) begin
        done_edge = cycle + 1; e = err; b = busy;
        break;
      end
      n++;
    end
    check_output("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_results(input string tag);
    for (int r = 0; r < 8; r++) begin
      res_addr = 3'(r);
      #1;
      check_output($sformatf("%s[%0d]", tag, r), 64'(res_data), 64'(model_res[r]));
    end
  endtask

  task automatic set_reads(input logic [31:0] base);
    for (int i = 0; i < 8; i++) rd_words[i] = base + 32'(i);
  endtask

  initial begin
    int s, d, n;
    logic e, b, done_any;
    for (int i = 0; i < 8; i++) begin model_res[i] = 32'h0; model_job[i] = 32'h0; rd_words[i] = 32'h0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_ctl", 64'({cyc, stb, we, sel, busy, done, err}), 64'd0);
    check_output("rst_bus", {adr, dat_o}, 64'd0);
    check_results("rst_res");
    @(posedge clk); #1 rst = 1'b0;

    // Nominal job with busy-time start/load attempts that must be ignored.
    apply_stimulus(3'd0, 32'h0102_0304);
    apply_stimulus(3'd1, 32'h0506_0708);
    apply_stimulus(3'd2, 32'h090A_0B0C);
    apply_stimulus(3'd3, 32'h0D0E_0F10);
    for (int i = 0; i < 4; i++) apply_stimulus(3'(4 + i), 32'(i + 1));
    rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33;
    rd_words[3] = 32'h44; rd_words[4] = 32'h55;
    lat = 1;
    build_expect();
    start_job(s);
    fork
      wait_done(200, d, e, b);
      begin
        repeat (5) @(posedge clk);
        #1 start = 1'b1; ld_we = 1'b1; ld_addr = 3'd0; ld_data = 32'hDEAD_BEEF;
        @(posedge clk); #1 start = 1'b0; ld_we = 1'b0;
      end
    join
    check_output("job_len_nominal", 64'(d - s), 64'd73);
    check_output("err_busy_nominal", 64'({e, b}), 64'd0);
    check_output("txn_left_nominal", 64'(exp_q.size()), 64'd0);
    check_output("reads_nominal", 64'(reads_seen), 64'd5);
    check_results("res_nominal");
    res_addr = 3'd4; #1;
    check_output("res4_literal", 64'(res_data), 64'h55);

    // Wait-state slave plus a spurious ack during the run wait.
    lat = 4;
    set_reads(32'hA000_0001);
    build_expect();
    start_job(s);
    fork
      wait_done(300, d, e, b);
      begin
        repeat (59) @(posedge clk);
        #1 check_output("stb_in_wait", 64'(stb), 64'd0);
        spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
      end
    join
    check_output("job_len_wait", 64'(d - s), 64'(job_len(4)));
    check_output("job_len_wait_lit", 64'(d - s), 64'd112);
    check_output("err_wait", 64'(e), 64'd0);
    check_output("reads_wait", 64'(reads_seen), 64'd5);
    check_output("txn_left_wait", 64'(exp_q.size()), 64'd0);
    check_results("res_wait");

    // Slave that never acks.
    never_ack = 1'b1;
    lat = 1;
    build_expect();
    start_job(s);
    wait_done(400, d, e, b);
    check_output("job_len_tmo", 64'(d - s), 64'd257);
    check_output("err_busy_tmo", 64'({e, b}), 64'b10);
    check_output("txn_left_tmo", 64'(exp_q.size()), 64'(NWORDS));
    repeat (3) @(negedge clk);
    check_output("err_held", 64'(err), 64'd1);
    check_results("res_tmo");
    never_ack = 1'b0;

    // The next start clears the error and the job runs normally.
    set_reads(32'hB000_0010);
    build_expect();
    start_job(s);
    wait_done(200, d, e, b);
    check_output("job_len_after_tmo", 64'(d - s), 64'd73);
    check_output("err_after_tmo", 64'(e), 64'd0);
    check_results("res_after_tmo");

    // Reset in the middle of the third result read.
    set_reads(32'hC000_0100);
    build_expect();
    start_job(s);
    n = 0;
    while (!(reads_seen == 2 && stb) && n < 200) begin @(negedge clk); n++; end
    check_output("reached_rd", 64'(reads_seen), 64'd2);
    res_addr = 3'd0; #1;
    check_output("res_before_rst", 64'(res_data), 64'(model_res[0]));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_ctl", 64'({cyc, stb, we, sel, busy, done, err}), 64'd0);
    check_output("midrst_bus", {adr, dat_o}, 64'd0);
    for (int i = 0; i < 8; i++) model_res[i] = 32'h0;
    exp_q.delete();
    reads_seen = 0;
    check_results("midrst_res");
    @(posedge clk); #1 rst = 1'b0;
    done_any = 1'b0;
    repeat (20) begin @(negedge clk); done_any |= done; end
    check_output("no_done_after_rst", 64'(done_any), 64'd0);

    set_reads(32'hD000_1000);
    build_expect();
    start_job(s);
    wait_done(200, d, e, b);
    check_output("job_len_fresh", 64'(d - s), 64'd73);
    check_output("err_fresh", 64'(e), 64'd0);
    check_output("reads_fresh", 64'(reads_seen), 64'd5);
    check_results("res_fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
